div_sign_ctrl: RTL and testbench

//  Front-end/sequencer for the RV32M divide path (DIV/DIVU/REM/REMU). Accepts operands from execute
//  via valid/ready, resolves signs and the ISA special cases, drives an unsigned radix-2 iterative core,

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_core_iter.sv | 55 +++++
 rtl/div_sign_ctrl.sv | 137 +++++++++++++
 tb/tb_div_sign_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the RV32M divide front-end: op encodings, sequencer states, default width.
package div_pkg;

    localparam int XLEN_DEF = 32;

    // funct3[1:0]: bit 0 selects unsigned, bit 1 selects remainder
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } div_state_e;

endpackage

// File: rtl/div_core_iter.sv
// Unsigned restoring radix-2 divider core: one quotient bit per step, MSB first.
module div_core_iter
    import div_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            step,
    output logic [XLEN-1:0] uq,
    output logic [XLEN-1:0] ur
);

    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] div_q;
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   trial;

    // The partial remainder stays below the divisor, so one extra bit is enough
    // for the trial subtract; its MSB is the borrow.
    always_comb begin
        rem_shift = {rem_q, quo_q[XLEN-1]};
        trial     = rem_shift - {1'b0, div_q};
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            div_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= a;
            div_q <= b;
        end else if (step) begin
            if (!trial[XLEN]) begin
                rem_q <= trial[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_q <= rem_shift[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    assign uq = quo_q;
    assign ur = rem_q;

endmodule

// File: rtl/div_sign_ctrl.sv
// RV32M divide sequencer: sign resolution, special cases, handshakes around div_core_iter.
// Optional DIV_EARLY_OUT_EN skips iteration when |divisor| > |dividend|.
module div_sign_ctrl
    import div_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state, state_nxt;
    logic [1:0]      op_q;
    logic [XLEN-1:0] a_q, b_q;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] result_q;
    logic            early_q;

    logic            accept;
    logic            neg_a, neg_b, q_neg, r_neg;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_zero, sgn_ovf, special, early_hit;
    logic [XLEN-1:0] special_val;
    logic [XLEN-1:0] uq, ur, uq_sel, ur_sel, q_fix, r_fix, fix_val;

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_DONE);
    assign result    = result_q;
    assign accept    = in_valid && in_ready && !flush;

    always_comb begin
        neg_a    = !op_q[0] && a_q[XLEN-1];
        neg_b    = !op_q[0] && b_q[XLEN-1];
        q_neg    = neg_a ^ neg_b;
        r_neg    = neg_a;
        mag_a    = neg_a ? -a_q : a_q;
        mag_b    = neg_b ? -b_q : b_q;
        div_zero = (b_q == '0);
        sgn_ovf  = !op_q[0] && (a_q == INT_MIN) && (b_q == '1);
        special  = div_zero || sgn_ovf;
        if (div_zero)
            special_val = op_q[1] ? a_q : '1;
        else
            special_val = op_q[1] ? '0 : a_q;
`ifdef DIV_EARLY_OUT_EN
        early_hit = (mag_b > mag_a);
`else
        early_hit = 1'b0;
`endif
        uq_sel  = early_q ? '0    : uq;
        ur_sel  = early_q ? mag_a : ur;
        q_fix   = q_neg ? -uq_sel : uq_sel;
        r_fix   = r_neg ? -ur_sel : ur_sel;
        fix_val = op_q[1] ? r_fix : q_fix;
    end

    div_core_iter #(.XLEN(XLEN)) u_core (
        .clk  (clk),
        .rst  (rst),
        .load (state == S_PREP),
        .a    (mag_a),
        .b    (mag_b),
        .step (state == S_ITER),
        .uq   (uq),
        .ur   (ur)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: next_state gets a default first so no path through the case leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        if (flush && state != S_IDLE) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: if (accept) state_nxt = S_PREP;
                S_PREP: begin
                    if (special)        state_nxt = S_DONE;
                    else if (early_hit) state_nxt = S_FIX;
                    else                state_nxt = S_ITER;
                end
                S_ITER: if (cnt == CNT_W'(XLEN-1)) state_nxt = S_FIX;
                S_FIX:  state_nxt = S_DONE;
                S_DONE: if (out_ready) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // A flush leaves the last delivered result untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt      <= '0;
            result_q <= '0;
            early_q  <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= op;
                a_q  <= rs1;
                b_q  <= rs2;
            end
            case (state)
                S_PREP: begin
                    cnt     <= '0;
                    early_q <= early_hit;
                    if (special && !flush) result_q <= special_val;
                end
                S_ITER: cnt <= cnt + CNT_W'(1);
                S_FIX:  if (!flush) result_q <= fix_val;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_sign_ctrl.sv
// Directed bench for div_sign_ctrl: latency, signs, special cases, hold, flush and reset.
module tb_div_sign_ctrl;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef DIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 3;
`else
    localparam int EARLY_LAT = 35;
`endif

    always #5 clk = ~clk;

    div_sign_ctrl #(.XLEN(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, measure edges from accept to out_valid, optionally stall, then handshake.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input int hold);
        int lat;
        bit got;
        @(negedge clk);
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; op = o; rs1 = a; rs2 = b;
        @(posedge clk);
        lat = 0;
        got = 0;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            in_valid = 1'b0;
            if (lat == 1) check({tag, " in_ready_busy"}, {31'd0, in_ready}, 32'd0);
            if (out_valid) got = 1;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, result, exp);
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            check({tag, " hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, " hold_result"}, result, exp);
            check({tag, " hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check({tag, " post_valid"}, 32'(out_valid), 32'd0);
        check({tag, " post_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int seen;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result", result, 32'd0);
        check("reset busy", 32'(busy), 32'd0);

        run_op("div_m7_2",    OP_DIV,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 35, 0);
        run_op("rem_m7_2",    OP_REM,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 35, 0);
        run_op("divu_x_0",    OP_DIVU, 32'hFFFF_FFFF, 32'd0,        32'hFFFF_FFFF, 2,  0);
        run_op("remu_x_0",    OP_REMU, 32'hFFFF_FFFF, 32'd0,        32'hFFFF_FFFF, 2,  0);
        run_op("rem_5_0",     OP_REM,  32'd5,         32'd0,        32'd5,         2,  0);
        run_op("div_ovf",     OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 0);
        run_op("rem_ovf",     OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        2,  0);
        run_op("divu_min_m1", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, EARLY_LAT, 0);
        run_op("divu_100_7",  OP_DIVU, 32'd100,       32'd7,        32'd14,        35, 0);
        run_op("remu_100_7",  OP_REMU, 32'd100,       32'd7,        32'd2,         35, 0);
        run_op("div_7_m2",    OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 35, 0);
        run_op("rem_7_m2",    OP_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,        35, 0);
        run_op("div_m7_m2",   OP_DIV,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,        35, 10);
        run_op("divu_3_10",   OP_DIVU, 32'd3,         32'd10,       32'd0,   EARLY_LAT, 0);
        run_op("remu_3_10",   OP_REMU, 32'd3,         32'd10,       32'd3,   EARLY_LAT, 0);

        // Flush at T+10 of DIV 100/3: op abandoned, nothing delivered.
        @(negedge clk);
        in_valid = 1'b1; op = OP_DIV; rs1 = 32'd100; rs2 = 32'd3;
        @(posedge clk);
        repeat (10) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check("flush in_ready", 32'(in_ready), 32'd1);
        check("flush busy", 32'(busy), 32'd0);
        check("flush result", result, 32'd3);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flush no_valid", 32'(seen), 32'd0);

        // Flush in IDLE with in_valid must block the accept.
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("flush_idle busy", 32'(busy), 32'd0);

        // Reset at T+20 of DIV 100/3: all outputs back to reset values.
        @(negedge clk);
        in_valid = 1'b1; op = OP_DIV; rs1 = 32'd100; rs2 = 32'd3;
        @(posedge clk);
        repeat (20) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst result", result, 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);

        run_op("div_100_3", OP_DIV, 32'd100, 32'd3, 32'd33, 35, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
